// File: rtl/proc_pkg.sv
// Shared fetch constants, state encoding and PC wrap helper.
// HALT_DETECT_EN adds the S_HALT state to the fetch encoding.
package proc_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 32;

  localparam logic [ADDR_W-1:0] RESET_PC    = '0;
  localparam logic [DATA_W-1:0] HALT_OPCODE = 32'hFFFF_FFFF;

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1
  } fetch_state_t;
`endif

  // IMEM_DEPTH is a power of two, so masking is the modulo
  function automatic logic [ADDR_W-1:0] wrapPc(input logic [ADDR_W-1:0] pc);
    return pc & ADDR_W'(IMEM_DEPTH - 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port plus the decode-side stream.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if;
  import proc_pkg::*;

  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_wea;
  logic [DATA_W-1:0] imem_dout;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              halted;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_dout,
    output imem_addr, imem_wea, instr, instr_pc, instr_valid, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_dout,
    input  imem_addr, imem_wea, instr, instr_pc, instr_valid, halted
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// Skid buffer for the instruction seen on the first stalled cycle; the BRAM
// keeps re-reading the next PC during a stall, so its output can't be trusted.
module fetch_hold_buf
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic              i_respValid,
  input  logic [DATA_W-1:0] i_memDout,
  output logic [DATA_W-1:0] o_instr
);

  logic              r_holdValid;
  logic [DATA_W-1:0] r_holdInstr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdValid <= 1'b0;
      r_holdInstr <= '0;
    end else if (i_redirect || !i_stall) begin
      r_holdValid <= 1'b0;
    end else if (i_respValid && !r_holdValid) begin
      r_holdValid <= 1'b1;
      r_holdInstr <= i_memDout;
    end
  end

  assign o_instr = r_holdValid ? r_holdInstr : i_memDout;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives BRAM address, tracks the 1-cycle read response,
// handles stall/redirect. Optional halt detection via HALT_DETECT_EN.
module instr_fetch_unit
  import proc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_respPc;
  logic              r_respValid;
  fetch_state_t      r_state;
  logic [DATA_W-1:0] w_instr;

  fetch_hold_buf u_holdBuf (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (bus.stall),
    .i_redirect  (bus.redirect_valid),
    .i_respValid (r_respValid),
    .i_memDout   (bus.imem_dout),
    .o_instr     (w_instr)
  );

`ifdef HALT_DETECT_EN
  logic w_haltHit;
  assign w_haltHit = r_respValid && !bus.stall && (w_instr == HALT_OPCODE);
`endif

  // S_START issues RESET_PC once without advancing, so PC 0 is the first response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_respPc    <= '0;
      r_respValid <= 1'b0;
      r_state     <= S_START;
    end else if (bus.redirect_valid) begin
      r_pc        <= wrapPc(bus.redirect_pc);
      r_respValid <= 1'b0;
      r_state     <= S_RUN;
    end else begin
      case (r_state)
        S_START: begin
          r_respValid <= 1'b0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
`ifdef HALT_DETECT_EN
          if (w_haltHit) begin
            r_respValid <= 1'b0;
            r_state     <= S_HALT;
          end else
`endif
          if (!bus.stall) begin
            r_pc        <= wrapPc(r_pc + 1'b1);
            r_respPc    <= r_pc;
            r_respValid <= 1'b1;
          end
        end
`ifdef HALT_DETECT_EN
        S_HALT: begin
          r_respValid <= 1'b0;
        end
`endif
        default: begin
          r_respValid <= 1'b0;
          r_state     <= S_START;
        end
      endcase
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.imem_wea    = 1'b0;
  assign bus.instr       = w_instr;
  assign bus.instr_pc    = r_respPc;
  assign bus.instr_valid = r_respValid;

`ifdef HALT_DETECT_EN
  assign bus.halted = (r_state == S_HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle BRAM model, mem[i] = i*16+1.
// Halt section runs only when HALT_DETECT_EN is defined.
module tb_instr_fetch_unit;
  import proc_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;
  logic [DATA_W-1:0] mem [IMEM_DEPTH];

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_dout <= mem[bus.imem_addr[4:0]];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic redir,
                               input logic [ADDR_W-1:0] redirPc);
    bus.stall          = stall;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redirPc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr);
    checkOutput({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
    checkOutput({tag, ".pc"}, bus.instr_pc, pc);
    checkOutput({tag, ".instr"}, bus.instr, instr);
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
    checkOutput({tag, ".wea"}, 32'(bus.imem_wea), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = 32'(i * 16 + 1);

    // Reset state and 2-cycle start-up latency
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst.pc", bus.instr_pc, 32'd0);
    checkOutput("rst.halted", 32'(bus.halted), 32'd0);
    checkOutput("rst.wea", 32'(bus.imem_wea), 32'd0);
    rst = 1'b0;
    tick();
    checkBubble("start");
    tick();
    checkFetch("first", 32'd0, 32'd1);
    for (int p = 1; p <= 5; p++) begin
      tick();
      checkFetch("seq", 32'(p), 32'(p * 16 + 1));
    end

    // Three stalled cycles on PC 5, then resume at 6
    applyStimulus(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkFetch("stall", 32'd5, 32'h51);
    end
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    checkFetch("unstall", 32'd6, 32'h61);
    tick();
    checkFetch("seq7", 32'd7, 32'h71);

    // Redirect to 20; in-flight PC 8 must be squashed
    applyStimulus(1'b0, 1'b1, 32'd20);
    tick();
    checkBubble("redir");
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    checkFetch("redirTgt", 32'd20, 32'h141);
    tick();
    checkFetch("seq21", 32'd21, 32'h151);

    // Stall to load the hold buffer, then stall+redirect to 3
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkFetch("stall21", 32'd21, 32'h151);
    applyStimulus(1'b1, 1'b1, 32'd3);
    tick();
    checkBubble("stallRedir");
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    checkFetch("stallRedirTgt", 32'd3, 32'h31);
    tick();
    checkFetch("seq4", 32'd4, 32'h41);
    checkOutput("seq4.halted", 32'(bus.halted), 32'd0);

    // Out-of-range redirect target wraps to 29, then PC wraps 31 -> 0
    applyStimulus(1'b0, 1'b1, 32'd61);
    tick();
    checkBubble("wrapRedir");
    applyStimulus(1'b0, 1'b0, '0);
    for (int p = 29; p < 34; p++) begin
      tick();
      checkFetch("wrap", 32'(p % 32), 32'((p % 32) * 16 + 1));
      checkOutput("wrap.addrHi", bus.imem_addr & 32'hFFFF_FFE0, 32'd0);
    end

    // Asynchronous reset pulse mid-cycle
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midRst.valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("midRst.pc", bus.instr_pc, 32'd0);
    checkOutput("midRst.wea", 32'(bus.imem_wea), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    checkBubble("restart");
    tick();
    checkFetch("restart0", 32'd0, 32'd1);
    tick();
    checkFetch("restart1", 32'd1, 32'h11);

`ifdef HALT_DETECT_EN
    mem[4] = HALT_OPCODE;
    tick();
    checkFetch("preHalt2", 32'd2, 32'h21);
    tick();
    checkFetch("preHalt3", 32'd3, 32'h31);
    tick();
    checkFetch("haltInstr", 32'd4, HALT_OPCODE);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("halt.halted", 32'(bus.halted), 32'd1);
      checkOutput("halt.valid", 32'(bus.instr_valid), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'd0);
    tick();
    checkOutput("resume.halted", 32'(bus.halted), 32'd0);
    checkBubble("resume");
    applyStimulus(1'b0, 1'b0, '0);
    tick();
    checkFetch("resume0", 32'd0, 32'd1);
`else
    tick();
    checkFetch("tail2", 32'd2, 32'h21);
    checkOutput("tail2.halted", 32'(bus.halted), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
